// File: rtl/cache_mem_arbiter_if.sv
// Bus bundle between the I/D caches, the memory arbiter and physical memory.
// master: arbiter view; slave: view of the caches/pmem environment around it.
interface cache_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
);
    logic              i_read;
    logic [ADDR_W-1:0] i_addr;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;
    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_addr;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;

    modport master (
        input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, pmem_rdata, pmem_resp,
        output i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_addr, pmem_wdata
    );

    modport slave (
        output i_read, i_addr, d_read, d_write, d_addr, d_wdata, pmem_rdata, pmem_resp,
        input  i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_addr, pmem_wdata
    );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing one physical-memory port between I-cache and D-cache.
// state  | meaning
// IDLE   | sample requests, pick winner, latch its address/data
// GNT_I  | I-cache line read in flight on pmem
// GNT_D  | D-cache line read or write-back in flight on pmem
// RESP_I | one-cycle i_resp pulse
// RESP_D | one-cycle d_resp pulse
module cache_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input logic               clk,
    input logic               rst,
    cache_mem_arbiter_if.master bus
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GNT_I  = 3'd1,
        GNT_D  = 3'd2,
        RESP_I = 3'd3,
        RESP_D = 3'd4
    } state_t;

    state_t            state;
    logic              last_grant_d;
    logic              d_is_write;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;
    logic [LINE_W-1:0] i_rdata_q;
    logic [LINE_W-1:0] d_rdata_q;
    logic              d_pend;
    logic              tie;

    assign d_pend = bus.d_read | bus.d_write;
    assign tie    = bus.i_read & d_pend;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            last_grant_d <= 1'b1;
            d_is_write   <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // last_grant only moves on a genuine tie, so an uncontested grant keeps the rotation
                    if (bus.i_read && (!d_pend || last_grant_d)) begin
                        state  <= GNT_I;
                        addr_q <= bus.i_addr;
                        if (tie) last_grant_d <= 1'b0;
                    end else if (d_pend) begin
                        state      <= GNT_D;
                        addr_q     <= bus.d_addr;
                        d_is_write <= bus.d_write;
                        if (bus.d_write) wdata_q <= bus.d_wdata;
                        if (tie) last_grant_d <= 1'b1;
                    end
                end
                GNT_I: begin
                    if (bus.pmem_resp) begin
                        i_rdata_q <= bus.pmem_rdata;
                        state     <= RESP_I;
                    end
                end
                GNT_D: begin
                    if (bus.pmem_resp) begin
                        if (!d_is_write) d_rdata_q <= bus.pmem_rdata;
                        state <= RESP_D;
                    end
                end
                RESP_I:  state <= IDLE;
                RESP_D:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.pmem_read  = (state == GNT_I) || ((state == GNT_D) && !d_is_write);
    assign bus.pmem_write = (state == GNT_D) && d_is_write;
    assign bus.pmem_addr  = addr_q;
    assign bus.pmem_wdata = wdata_q;
    assign bus.i_resp     = (state == RESP_I);
    assign bus.d_resp     = (state == RESP_D);
    assign bus.i_rdata    = i_rdata_q;
    assign bus.d_rdata    = d_rdata_q;
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: I read, D write-back, ties, held inputs, flush, reset mid-grant.
module tb_cache_mem_arbiter;
    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    cache_mem_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

    cache_mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [LINE_W-1:0] LINE_AA = {32{8'hAA}};
    localparam logic [LINE_W-1:0] LINE_55 = {32{8'h55}};

    task automatic chk_val(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pmem_answer(input logic [LINE_W-1:0] data);
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = data;
        step();
        bus.pmem_resp  = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst            = 1'b0;
        bus.i_read     = 1'b0;
        bus.i_addr     = '0;
        bus.d_read     = 1'b0;
        bus.d_write    = 1'b0;
        bus.d_addr     = '0;
        bus.d_wdata    = '0;
        bus.pmem_rdata = '0;
        bus.pmem_resp  = 1'b0;
        step();
        step();
        chk_val("rst_pread",  LINE_W'(bus.pmem_read),  '0);
        chk_val("rst_pwrite", LINE_W'(bus.pmem_write), '0);
        chk_val("rst_resps",  LINE_W'({bus.i_resp, bus.d_resp}), '0);
        chk_val("rst_addr",   LINE_W'(bus.pmem_addr),  '0);
        chk_val("rst_rdata",  bus.i_rdata | bus.d_rdata | bus.pmem_wdata, '0);
        rst = 1'b1;

        // I-only read, pmem answers 4 cycles after the strobe
        bus.i_read = 1'b1;
        bus.i_addr = 32'h0000_1000;
        step();
        chk_val("i_pread", LINE_W'(bus.pmem_read), 1);
        chk_val("i_paddr", LINE_W'(bus.pmem_addr), 32'h1000);
        chk_val("i_pwrite", LINE_W'(bus.pmem_write), 0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk_val("i_pread_hold", LINE_W'(bus.pmem_read), 1);
        end
        pmem_answer(LINE_AA);
        chk_val("i_resp", LINE_W'({bus.i_resp, bus.d_resp}), 2'b10);
        chk_val("i_rdata", bus.i_rdata, LINE_AA);
        chk_val("i_resp_pread", LINE_W'(bus.pmem_read), 0);
        bus.i_read = 1'b0;
        step();
        chk_val("i_resp_drop", LINE_W'({bus.i_resp, bus.d_resp}), 0);

        // D write-back with address/data changed mid-grant
        bus.d_write = 1'b1;
        bus.d_addr  = 32'h0000_2000;
        bus.d_wdata = LINE_55;
        step();
        chk_val("dw_pwrite", LINE_W'({bus.pmem_write, bus.pmem_read}), 2'b10);
        chk_val("dw_wdata", bus.pmem_wdata, LINE_55);
        chk_val("dw_addr", LINE_W'(bus.pmem_addr), 32'h2000);
        bus.d_addr  = 32'h0000_3000;
        bus.d_wdata = '0;
        step();
        chk_val("dw_addr_held", LINE_W'(bus.pmem_addr), 32'h2000);
        chk_val("dw_wdata_held", bus.pmem_wdata, LINE_55);
        pmem_answer(256'h1234);
        chk_val("dw_resp", LINE_W'({bus.i_resp, bus.d_resp}), 2'b01);
        chk_val("dw_rdata_kept", bus.d_rdata, '0);
        chk_val("dw_resp_strobes", LINE_W'({bus.pmem_write, bus.pmem_read}), 0);
        chk_val("dw_resp_addr", LINE_W'(bus.pmem_addr), 32'h2000);
        bus.d_write = 1'b0;
        step();
        chk_val("dw_resp_drop", LINE_W'(bus.d_resp), 0);

        // first tie: I wins, then D alone
        bus.i_read = 1'b1;
        bus.i_addr = 32'h100;
        bus.d_read = 1'b1;
        bus.d_addr = 32'h200;
        step();
        chk_val("tie1_addr", LINE_W'(bus.pmem_addr), 32'h100);
        pmem_answer(256'h11);
        chk_val("tie1_iresp", LINE_W'({bus.i_resp, bus.d_resp}), 2'b10);
        chk_val("tie1_irdata", bus.i_rdata, 256'h11);
        bus.i_read = 1'b0;
        step();
        chk_val("tie1_idle", LINE_W'({bus.pmem_read, bus.i_resp, bus.d_resp}), 0);
        step();
        chk_val("tie1_d_pread", LINE_W'(bus.pmem_read), 1);
        chk_val("tie1_d_addr", LINE_W'(bus.pmem_addr), 32'h200);
        pmem_answer(256'h22);
        chk_val("tie1_dresp", LINE_W'({bus.i_resp, bus.d_resp}), 2'b01);
        chk_val("tie1_drdata", bus.d_rdata, 256'h22);
        bus.d_read = 1'b0;
        step();

        // second tie: D wins this time
        bus.i_read = 1'b1;
        bus.i_addr = 32'h300;
        bus.d_read = 1'b1;
        bus.d_addr = 32'h400;
        step();
        chk_val("tie2_addr", LINE_W'(bus.pmem_addr), 32'h400);
        pmem_answer(256'h44);
        chk_val("tie2_dresp", LINE_W'({bus.i_resp, bus.d_resp}), 2'b01);
        bus.d_read = 1'b0;
        step();
        step();
        chk_val("tie2_i_addr", LINE_W'(bus.pmem_addr), 32'h300);
        chk_val("tie2_i_pread", LINE_W'(bus.pmem_read), 1);
        pmem_answer(256'h33);
        chk_val("tie2_iresp", LINE_W'({bus.i_resp, bus.d_resp}), 2'b10);
        chk_val("tie2_irdata", bus.i_rdata, 256'h33);
        bus.i_read = 1'b0;
        step();

        // flush: I request dropped one cycle after grant
        bus.i_read = 1'b1;
        bus.i_addr = 32'h500;
        step();
        chk_val("fl_pread0", LINE_W'(bus.pmem_read), 1);
        step();
        bus.i_read = 1'b0;
        bus.i_addr = 32'h0;
        step();
        chk_val("fl_pread1", LINE_W'(bus.pmem_read), 1);
        chk_val("fl_addr", LINE_W'(bus.pmem_addr), 32'h500);
        pmem_answer(256'h55);
        chk_val("fl_iresp", LINE_W'({bus.i_resp, bus.d_resp}), 2'b10);
        step();
        chk_val("fl_once_a", LINE_W'({bus.i_resp, bus.pmem_read}), 0);
        step();
        chk_val("fl_once_b", LINE_W'({bus.i_resp, bus.pmem_read}), 0);

        // pmem_resp while idle is ignored
        pmem_answer(256'h66);
        chk_val("idle_presp", LINE_W'({bus.i_resp, bus.d_resp, bus.pmem_read}), 0);
        chk_val("idle_rdata", bus.i_rdata, 256'h55);

        // reset mid-grant
        bus.d_read = 1'b1;
        bus.d_addr = 32'h600;
        step();
        chk_val("rg_pread", LINE_W'(bus.pmem_read), 1);
        rst = 1'b0;
        step();
        chk_val("rg_strobes", LINE_W'({bus.pmem_read, bus.pmem_write, bus.i_resp, bus.d_resp}), 0);
        chk_val("rg_addr", LINE_W'(bus.pmem_addr), 0);
        chk_val("rg_drdata", bus.d_rdata, 0);
        rst = 1'b1;
        bus.d_read = 1'b0;
        pmem_answer(256'h77);
        chk_val("rg_late_presp", LINE_W'({bus.pmem_read, bus.i_resp, bus.d_resp}), 0);
        step();
        chk_val("rg_late_presp2", LINE_W'({bus.i_resp, bus.d_resp}), 0);
        chk_val("rg_late_rdata", bus.d_rdata, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
